// File: rtl/count_sched_pkg.sv
// Shared types and default sizes for the round-robin slot scheduler.
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 5;

endpackage

// File: rtl/count_sched_if.sv
// Requester-side bundle: level requests, packed lengths, abort, and the scheduler's responses.
interface count_sched_if
    import count_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic              abort;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      count;

    modport master (
        output req, len, abort,
        input  gnt, busy, done, count
    );

    modport slave (
        input  req, len, abort,
        output gnt, busy, done, count
    );
endinterface

// File: rtl/count_sched_slot_counter.sv
// W-bit wrapping up-counter; reset beats load, load beats enable.
module slot_counter
    import count_sched_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         i_load,
    input  logic         i_enable,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_data;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one slot_counter among NREQ requesters for len-cycle slots.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic         clk,
    input  logic         rst_,
    count_sched_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t  r_state;
    sched_state_t  w_nextState;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_idx;
    logic [W-1:0]  r_lenQ;
    logic [PW-1:0] w_pick;
    logic [PW-1:0] w_idxNext;
    logic [W-1:0]  w_lenM1;
    logic [W-1:0]  w_count;
    logic [NREQ-1:0] w_idxOneHot;
    logic          w_any;
    logic          w_last;
    logic          w_load;
    logic          w_enable;

    // Scan from ptr upward; descending loop so the nearest set bit is the last to win.
    always_comb begin
        int c;
        w_pick = r_ptr;
        w_any  = |bus.req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(r_ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (bus.req[c]) begin
                w_pick = PW'(c);
            end
        end
    end

    assign w_idxNext   = (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
    assign w_lenM1     = r_lenQ - 1'b1;
    assign w_last      = (w_count == w_lenM1);
    assign w_idxOneHot = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_lenQ  <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_any) begin
                r_idx  <= w_pick;
                r_lenQ <= bus.len[w_pick*W +: W];
            end
            if (r_state == DONE || ((r_state == LOAD || r_state == RUN) && bus.abort)) begin
                r_ptr <= w_idxNext;
            end
        end
    end

    // Abort cancels both the load and the count step so the counter freezes where it was.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_enable    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else if (w_last) begin
                    w_nextState = DONE;
                end else begin
                    w_enable = 1'b1;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    slot_counter #(.W(W)) u_counter (
        .clk      (clk),
        .rst_     (rst_),
        .i_load   (w_load),
        .i_enable (w_enable),
        .i_data   ('0),
        .o_count  (w_count)
    );

    assign bus.gnt   = (r_state == LOAD || r_state == RUN) ? w_idxOneHot : '0;
    assign bus.done  = (r_state == DONE) ? w_idxOneHot : '0;
    assign bus.busy  = (r_state != IDLE);
    assign bus.count = w_count;
endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: hand-computed grant, count and done sequences per cycle.
module tb_count_sched;
    localparam int NREQ = 4;
    localparam int W    = 5;

    logic clk;
    logic rst_;
    int   vectorCount;
    int   missCount;

    count_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    count_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NREQ*W-1:0] packLen(input int l0, input int l1, input int l2, input int l3);
        logic [NREQ*W-1:0] v;
        v = '0;
        v[0*W +: W] = W'(l0);
        v[1*W +: W] = W'(l1);
        v[2*W +: W] = W'(l2);
        v[3*W +: W] = W'(l3);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] reqV, input logic [NREQ*W-1:0] lenV, input logic abortV);
        bus.req   = reqV;
        bus.len   = lenV;
        bus.abort = abortV;
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_ = 1'b0;
        applyStimulus('0, '0, 1'b0);
        tick();
        tick();
        rst_ = 1'b1;
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rst_        = 1'b0;
        applyStimulus('0, '0, 1'b0);

        // Single slot on requester 2, len 3.
        doReset();
        checkOutput("rst gnt", 32'(bus.gnt), 32'h0);
        checkOutput("rst busy", 32'(bus.busy), 32'h0);
        checkOutput("rst done", 32'(bus.done), 32'h0);
        checkOutput("rst count", 32'(bus.count), 32'h0);
        applyStimulus(4'b0100, packLen(0, 0, 3, 0), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 0, 3, 0), 1'b0);
        checkOutput("t1 load gnt", 32'(bus.gnt), 32'h4);
        checkOutput("t1 load busy", 32'(bus.busy), 32'h1);
        checkOutput("t1 load count", 32'(bus.count), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t1 run gnt", 32'(bus.gnt), 32'h4);
            checkOutput("t1 run count", 32'(bus.count), 32'(k));
            checkOutput("t1 run done", 32'(bus.done), 32'h0);
        end
        tick();
        checkOutput("t1 done pulse", 32'(bus.done), 32'h4);
        checkOutput("t1 done gnt", 32'(bus.gnt), 32'h0);
        checkOutput("t1 done count", 32'(bus.count), 32'h2);
        checkOutput("t1 done busy", 32'(bus.busy), 32'h1);
        tick();
        checkOutput("t1 idle busy", 32'(bus.busy), 32'h0);
        checkOutput("t1 idle done", 32'(bus.done), 32'h0);

        // All four requesting with len 1: rotation 0,1,2,3,0.
        doReset();
        applyStimulus(4'b1111, packLen(1, 1, 1, 1), 1'b0);
        for (int s = 0; s < 5; s++) begin
            tick();
            checkOutput("rr load gnt", 32'(bus.gnt), 32'(1 << (s % 4)));
            tick();
            checkOutput("rr run count", 32'(bus.count), 32'h0);
            checkOutput("rr run gnt", 32'(bus.gnt), 32'(1 << (s % 4)));
            tick();
            checkOutput("rr done", 32'(bus.done), 32'(1 << (s % 4)));
            tick();
            checkOutput("rr idle busy", 32'(bus.busy), 32'h0);
        end
        applyStimulus(4'b0000, packLen(1, 1, 1, 1), 1'b0);

        // len 0 on requester 0 means a 32-cycle slot.
        doReset();
        applyStimulus(4'b0001, packLen(0, 7, 7, 7), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 7, 7, 7), 1'b0);
        checkOutput("wrap load gnt", 32'(bus.gnt), 32'h1);
        for (int k = 0; k < 32; k++) begin
            tick();
            checkOutput("wrap run count", 32'(bus.count), 32'(k));
        end
        tick();
        checkOutput("wrap done", 32'(bus.done), 32'h1);
        checkOutput("wrap done count", 32'(bus.count), 32'd31);
        tick();
        checkOutput("wrap idle count", 32'(bus.count), 32'd31);
        checkOutput("wrap idle busy", 32'(bus.busy), 32'h0);

        // Abort at count 5: no done, count holds, requester 1 next.
        doReset();
        applyStimulus(4'b0011, packLen(10, 2, 0, 0), 1'b0);
        tick();
        checkOutput("abort load gnt", 32'(bus.gnt), 32'h1);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        checkOutput("abort pre count", 32'(bus.count), 32'h5);
        applyStimulus(4'b0011, packLen(10, 2, 0, 0), 1'b1);
        tick();
        applyStimulus(4'b0011, packLen(10, 2, 0, 0), 1'b0);
        checkOutput("abort idle busy", 32'(bus.busy), 32'h0);
        checkOutput("abort no done", 32'(bus.done), 32'h0);
        checkOutput("abort gnt", 32'(bus.gnt), 32'h0);
        checkOutput("abort count hold", 32'(bus.count), 32'h5);
        tick();
        checkOutput("abort next gnt", 32'(bus.gnt), 32'h2);
        applyStimulus(4'b0000, packLen(10, 2, 0, 0), 1'b0);

        // Reset mid-RUN at count 4, then requester 3 alone.
        doReset();
        applyStimulus(4'b0010, packLen(0, 10, 0, 0), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 10, 0, 0), 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        checkOutput("mid rst pre count", 32'(bus.count), 32'h4);
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        checkOutput("mid rst gnt", 32'(bus.gnt), 32'h0);
        checkOutput("mid rst busy", 32'(bus.busy), 32'h0);
        checkOutput("mid rst done", 32'(bus.done), 32'h0);
        checkOutput("mid rst count", 32'(bus.count), 32'h0);
        applyStimulus(4'b1000, packLen(0, 10, 0, 2), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 10, 0, 2), 1'b0);
        checkOutput("post rst gnt", 32'(bus.gnt), 32'h8);
        checkOutput("post rst done", 32'(bus.done), 32'h0);

        // Request dropped after grant still completes all 6 RUN cycles.
        doReset();
        applyStimulus(4'b0010, packLen(0, 6, 0, 0), 1'b0);
        tick();
        applyStimulus(4'b0000, packLen(0, 1, 0, 0), 1'b0);
        checkOutput("drop load gnt", 32'(bus.gnt), 32'h2);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("drop run gnt", 32'(bus.gnt), 32'h2);
            checkOutput("drop run count", 32'(bus.count), 32'(k));
        end
        tick();
        checkOutput("drop done", 32'(bus.done), 32'h2);
        checkOutput("drop done count", 32'(bus.count), 32'h5);
        tick();
        checkOutput("drop idle busy", 32'(bus.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/count_sched.md
# count_sched

Round-robin scheduler that time-shares one 5-bit loadable up-counter among `NREQ` requesters. Each requester asks for a timed slot of `len` cycles. The block arbitrates, loads the counter, enables it for exactly the requested length, then issues a per-requester completion pulse. It sits between requesting agents and the slot counter, and owns the counter's `load`/`enable`/`data` sequencing.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8)
- `W`, 5: counter and length width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_`  in  1  reset, synchronous, active-low
- `req`  in  NREQ  per-requester slot request (level)
- `len`  in  NREQ*W  packed lengths; requester i uses bits [i*W +: W]; 0 means 2^W
- `abort`  in  1  cancel the current slot
- `gnt`  out  NREQ  one-hot grant, asserted in LOAD and RUN
- `busy`  out  1  state != IDLE
- `done`  out  NREQ  one-cycle pulse on the granted index when a slot completes
- `count`  out  W  current slot counter value

## Operation
- States: IDLE, LOAD, RUN, DONE. Registered `ptr` (log2 NREQ bits) holds the highest-priority index.
- **IDLE:**
  - If any `req` bit is set, select the first set bit scanning `ptr`, `ptr+1`, … modulo NREQ.
  - Latch `idx` and `len_q = len[idx]`, then go to LOAD.
  - With no request, stay in IDLE.
- **LOAD:** counter load = 1, data = 0. Go to RUN.
- **RUN:**
  - Counter enable = 1 while `count != len_q - 1`, with the subtraction taken modulo 2^W.
  - When `count == len_q - 1`, go to DONE; the counter holds.
  - RUN therefore lasts exactly `len_q` cycles. `len_q = 0` wraps to 2^W − 1, giving 32 cycles for W = 5.
- **DONE:**
  - `done[idx]` = 1 for one cycle.
  - `ptr <= (idx+1) mod NREQ`.
  - Go to IDLE.
- **abort:**
  - Sampled only in LOAD or RUN; abort in LOAD takes priority over the load.
  - Next state is IDLE, with no `done` pulse.
  - `ptr` advances past `idx`; the counter holds its value.
- **req withdrawal after grant:** ignored. The slot runs to completion and `done` is still issued.
- **len changes after latch:** ignored.
- **count:** holds its last value in DONE and IDLE until the next LOAD.
- **Reset** (`rst_` = 0 at a rising edge, any state, including mid-RUN):
  - state = IDLE, `ptr` = 0, `gnt` = 0, `done` = 0, `busy` = 0, `count` = 0.
  - No `done` pulse is issued for the interrupted slot.
  - Reset dominates `abort` and `req`.

## Timing
- `req[i]` is sampled at the edge ending IDLE cycle t.
- t+1: LOAD. `gnt[i]` = 1, `busy` = 1, `count` still holds its old value.
- t+2 … t+1+len: RUN, with `count` = 0, 1, …, len−1.
- t+2+len: DONE. `gnt` = 0, `done[i]` = 1, `count` = len−1, `busy` = 1.
- t+3+len: IDLE. `busy` = 0. The next arbitration happens this cycle.
- Back-to-back slot period is len+3 cycles.
- All outputs are registered or decoded from registered state. There are no combinational paths from `req`, `len` or `abort` to outputs.

## Structure
- Package `count_sched_pkg`:
  - state enum `sched_state_t` {IDLE, LOAD, RUN, DONE}
  - default constants `NREQ_DEF` = 4 and `W_DEF` = 5
- Sub-module `slot_counter`: W-bit up-counter with synchronous active-low `rst_`, then `load` (priority), then `enable`, in that priority order. It wraps modulo 2^W.
- `count_sched` contains the FSM, the round-robin picker, the `idx`/`len_q`/`ptr` registers, and one `slot_counter` instance driving `count`.

## Test plan
- Reset, then `req` = 0100 with `len[2]` = 3 for one cycle:
  - `gnt` = 0100 for 4 cycles (LOAD + 3 RUN).
  - `count` reads 0, 1, 2 in RUN.
  - `done` = 0100 in the next cycle, `count` holds 2, then `busy` = 0.
- `req` = 1111 held with all `len` = 1 from reset:
  - Grants go in order 0, 1, 2, 3, 0.
  - Each slot spans 4 cycles (LOAD, RUN, DONE, IDLE).
  - `done` pulses in matching order.
- `len[0]` = 0:
  - RUN lasts 32 cycles with `count` 0 … 31.
  - `done[0]` follows, and `count` holds 31.
- `req` = 0011 with `len[0]` = 10, `abort` pulsed when `count` = 5:
  - Next cycle is IDLE, `done` stays 0, `count` holds 5.
  - Requester 1 is granted next.
- `rst_` low for one edge mid-RUN (`count` = 4):
  - All outputs become 0 after that edge, with no `done` pulse.
  - With `req` = 1000 afterwards, arbitration restarts from `ptr` = 0 and grants 3.
- `req[1]` dropped during RUN (`len[1]` = 6):
  - The slot completes its full 6 RUN cycles.
  - `done` = 0010 is issued.
